// File: rtl/sensor_debouncer.sv
// -----------------------------------------------------------------------------
// sensor_debouncer
//
// Front-end conditioning for the two gate photo-sensors (A = outer, B = inner).
// Each raw line is brought into the clk domain by a two-flop synchronizer.
// A per-channel debounce counter then lets the output follow only once the
// synchronized level has differed from it for DB_CYCLES consecutive edges.
// Sensor polarity is active-high: 1 means the beam is blocked.
//
// Optional feature (macro SENSOR_FAULT_EN):
//   A saturating counter watches for both clean outputs being high together.
//   After FAULT_CYCLES consecutive such edges a sticky fault flag is raised.
//   The flag stays set until reset. Without the macro, fault is tied to 0.
//
// Parameters:
//   DB_CYCLES     number of edges a new level must hold before the output
//                 follows it (must be >= 2)
//   FAULT_CYCLES  number of edges with A && B before fault asserts
//
// Ports:
//   clk     system clock; all state changes on its rising edge
//   reset   asynchronous, active-high; clears all state
//   raw_A   raw outer sensor, asynchronous to clk
//   raw_B   raw inner sensor, asynchronous to clk
//   A       debounced, synchronized A (registered)
//   B       debounced, synchronized B (registered)
//   fault   sticky "both sensors blocked too long" flag
// -----------------------------------------------------------------------------
module sensor_debouncer #(
    parameter int DB_CYCLES    = 4,
    parameter int FAULT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_A,
    input  logic raw_B,
    output logic A,
    output logic B,
    output logic fault
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    // Bit 0 carries channel A and bit 1 carries channel B throughout.
    logic [1:0]    raw;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    out;
    logic [CW-1:0] cnt [2];

    assign raw = {raw_B, raw_A};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Any sample that agrees with the output clears the count. A partial
    // count therefore never survives a glitch back to the current level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                cnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (s2[ch] == out[ch]) begin
                    cnt[ch] <= '0;
                end else if (cnt[ch] == CNT_MAX) begin
                    out[ch] <= s2[ch];
                    cnt[ch] <= '0;
                end else begin
                    cnt[ch] <= cnt[ch] + 1'b1;
                end
            end
        end
    end

    assign A = out[0];
    assign B = out[1];

`ifdef SENSOR_FAULT_EN
    localparam int FW = $clog2(FAULT_CYCLES + 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(FAULT_CYCLES);

    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_next;
    logic          fault_q;

    // This looks at the registered outputs. The first increment therefore
    // lands on the edge after A && B becomes visible.
    always_comb begin
        fcnt_next = '0;
        if (out[0] && out[1]) begin
            fcnt_next = (fcnt == FCNT_MAX) ? fcnt : fcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt    <= '0;
            fault_q <= 1'b0;
        end else begin
            fcnt <= fcnt_next;
            if (fcnt_next == FCNT_MAX) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule
